// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// Each transaction occupies the RAM for HOLD cycles, then reports completion with a done pulse.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned HOLD   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [15:0]       rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_d,
  output logic              ram_r,
  output logic              ram_w,
  input  logic [15:0]       ram_o
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // Counter runs HOLD-1 down to 0; 0 marks the last ACCESS cycle.
  localparam logic [3:0] CntLoad = 4'(HOLD - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic                r_sel;
  logic                r_ptr;
  logic [3:0]          r_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;

  logic                w_start;
  logic                w_pick;
  logic                w_last;
  logic                w_access;
  logic                w_first;

  assign w_start  = req0 | req1;
  // A lone requester wins outright; the pointer only breaks ties.
  assign w_pick   = (req0 && req1) ? r_ptr : req1;
  assign w_last   = (r_cnt == 4'd0);
  assign w_access = (r_state == StAccess);
  assign w_first  = w_access && (r_cnt == CntLoad);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:   if (w_start) w_state_next = StAccess;
      StAccess: if (w_last) w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    gnt0     = w_first && !r_sel;
    gnt1     = w_first && r_sel;
    done0    = (r_state == StDone) && !r_sel;
    done1    = (r_state == StDone) && r_sel;
    ram_w    = w_access && r_we;
    ram_r    = w_access && !r_we;
    ram_addr = r_addr;
    ram_d    = r_wdata;
    rdata    = r_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_sel   <= 1'b0;
      r_ptr   <= 1'b0;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 16'h0000;
      r_rdata <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_sel   <= w_pick;
            r_cnt   <= CntLoad;
            r_we    <= w_pick ? we1 : we0;
            r_addr  <= w_pick ? addr1 : addr0;
            r_wdata <= w_pick ? wdata1 : wdata0;
          end
        end
        StAccess: begin
          if (w_last) begin
            if (!r_we) r_rdata <= ram_o;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDone: r_ptr <= ~r_sel;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table-driven transactions checked through a done-time scoreboard,
// plus hand sequences for latency, round-robin, early release, mid-access reset and HOLD=1.
module tb_ram_arbiter;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [15:0]   wdata0, wdata1;
  logic          gnt0, gnt1, done0, done1, ram_r, ram_w;
  logic [15:0]   rdata, ram_d, ram_o;
  logic [AW-1:0] ram_addr;

  logic          b_req0, b_req1, b_we0, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [15:0]   b_wdata0, b_wdata1;
  logic          b_gnt0, b_gnt1, b_done0, b_done1, b_ram_r, b_ram_w;
  logic [15:0]   b_rdata, b_ram_d, b_ram_o;
  logic [AW-1:0] b_ram_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .ram_addr(ram_addr), .ram_d(ram_d), .ram_r(ram_r), .ram_w(ram_w), .ram_o(ram_o)
  );

  ram_arbiter #(.ADDR_W(AW), .HOLD(1)) u_dut_h1 (
    .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .ram_addr(b_ram_addr), .ram_d(b_ram_d), .ram_r(b_ram_r), .ram_w(b_ram_w),
    .ram_o(b_ram_o)
  );

  // Behavioural RAM for the main instance; the HOLD=1 instance reads an address-derived pattern.
  logic [15:0] ram_a [64];
  always @(posedge clk) if (ram_w) ram_a[ram_addr] <= ram_d;
  assign ram_o   = ram_r ? ram_a[ram_addr] : 16'hdead;
  assign b_ram_o = b_ram_r ? {8'h5a, 2'b00, b_ram_addr} : 16'hdead;

  logic [43:0] all_out, b_all_out;
  assign all_out   = {gnt0, gnt1, done0, done1, ram_r, ram_w, rdata, ram_addr, ram_d};
  assign b_all_out = {b_gnt0, b_gnt1, b_done0, b_done1, b_ram_r, b_ram_w, b_rdata, b_ram_addr,
                      b_ram_d};

  typedef struct {
    bit          id;
    bit          we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          id;
    logic [15:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  vec_t        tbl[10];
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic set_req(input bit id, input bit r, input bit we, input logic [5:0] a,
                         input logic [15:0] d);
    if (!id) begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic wait_gnt(output logic [1:0] gv);
    gv = 2'b00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        gv = {gnt1, gnt0};
        break;
      end
    end
    if (gv == 2'b00) fail("gnt_wait");
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) fail("done_wait");
  endtask

  task automatic do_txn(input vec_t v);
    logic [1:0]  gv;
    logic [31:0] rnd;
    set_req(v.id, 1'b1, v.we, v.addr, v.wdata);
    sb.push_back('{v.id, v.exp_rdata});
    wait_gnt(gv);
    check("txn_gnt", gv, v.id ? 2'b10 : 2'b01);
    check("txn_ram_addr", ram_addr, v.addr);
    check("txn_ram_wr", {ram_w, ram_r}, v.we ? 2'b10 : 2'b01);
    // Scramble the request fields after the grant; the latched transaction must not notice.
    rnd = $urandom;
    set_req(v.id, 1'b0, rnd[0], rnd[6:1], rnd[31:16]);
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("reset_outs", all_out, 44'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 || gnt1) check("gnt_excl", gnt0 & gnt1, 1'b0);
      if (done0 || done1) begin
        check("done_excl", done0 & done1, 1'b0);
        if (sb.size() == 0) begin
          check("unexpected_done", {done1, done0}, 2'b00);
        end else begin
          m_e = sb.pop_front();
          check("done_id", {done1, done0}, m_e.id ? 2'b10 : 2'b01);
          check("done_rdata", rdata, m_e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int last, ndone, nr, ng;
    tbl[0] = '{1'b0, 1'b1, 6'd9,  16'h1111, 16'ha5a5};
    tbl[1] = '{1'b1, 1'b1, 6'd9,  16'h9999, 16'ha5a5};
    tbl[2] = '{1'b0, 1'b0, 6'd9,  16'h0000, 16'h9999};
    tbl[3] = '{1'b1, 1'b1, 6'd33, 16'h0f0f, 16'h9999};
    tbl[4] = '{1'b0, 1'b1, 6'd63, 16'hffff, 16'h9999};
    tbl[5] = '{1'b1, 1'b0, 6'd63, 16'h0000, 16'hffff};
    tbl[6] = '{1'b0, 1'b0, 6'd33, 16'h0000, 16'h0f0f};
    tbl[7] = '{1'b1, 1'b1, 6'd0,  16'h8001, 16'h0f0f};
    tbl[8] = '{1'b1, 1'b0, 6'd0,  16'h0000, 16'h8001};
    tbl[9] = '{1'b0, 1'b0, 6'd5,  16'h0000, 16'ha5a5};

    rst = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    set_req(1'b1, 1'b0, 1'b0, 6'd0, 16'h0);
    b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
    b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", all_out, 44'h0);
    check("reset_outs_h1", b_all_out, 44'h0);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_outs", all_out, 44'h0);
    end

    // Write latency: gnt at E+1, ram_w for two cycles, done at E+3.
    set_req(1'b0, 1'b1, 1'b1, 6'd5, 16'ha5a5);
    sb.push_back('{1'b0, 16'h0000});
    @(negedge clk);
    check("wr_gnt_e1", {gnt1, gnt0}, 2'b01);
    check("wr_ram_e1", {ram_w, ram_r, ram_addr, ram_d}, {2'b10, 6'd5, 16'ha5a5});
    set_req(1'b0, 1'b0, 1'b0, 6'h3f, 16'h0);
    @(negedge clk);
    check("wr_e2", {gnt0, done0, ram_w, ram_r}, 4'b0010);
    @(negedge clk);
    check("wr_done_e3", {done0, ram_w, ram_r}, 3'b100);
    @(negedge clk);
    check("idle_hold_ram", {ram_w, ram_r, ram_addr, ram_d}, {2'b00, 6'd5, 16'ha5a5});
    do_txn('{1'b0, 1'b0, 6'd5, 16'h0000, 16'ha5a5});
    check("rd_back_a5a5", rdata, 16'ha5a5);

    for (int i = 0; i < 10; i++) do_txn(tbl[i]);

    // Round-robin with both requests held after reset.
    do_reset();
    set_req(1'b0, 1'b1, 1'b0, 6'd63, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 6'd33, 16'h0);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      check("rr_order", g, (k % 2 == 1) ? 2'b10 : 2'b01);
      sb.push_back((k % 2 == 1) ? '{1'b1, 16'h0f0f} : '{1'b0, 16'hffff});
    end
    req0 = 1'b0;
    req1 = 1'b0;
    drain();

    // Early release with an address change in the grant cycle.
    set_req(1'b1, 1'b1, 1'b0, 6'd9, 16'h0);
    wait_gnt(g);
    check("early_gnt1", g, 2'b10);
    sb.push_back('{1'b1, 16'h9999});
    set_req(1'b1, 1'b0, 1'b0, 6'd3, 16'h0);
    check("early_addr_a", ram_addr, 6'd9);
    @(negedge clk);
    check("early_addr_b", {ram_r, ram_addr}, {1'b1, 6'd9});
    drain();
    check("early_rdata", rdata, 16'h9999);

    // Reset in the second ACCESS cycle of a write; pointer is at requester 1 beforehand.
    do_txn('{1'b0, 1'b0, 6'd0, 16'h0000, 16'h8001});
    set_req(1'b0, 1'b1, 1'b1, 6'd20, 16'h1234);
    wait_gnt(g);
    check("abort_gnt0", g, 2'b01);
    set_req(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
    @(negedge clk);
    check("abort_ram_w", ram_w, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_rst_outs", all_out, 44'h0);
    @(negedge clk);
    check("abort_no_done", all_out, 44'h0);
    set_req(1'b0, 1'b1, 1'b0, 6'd0, 16'h0);
    set_req(1'b1, 1'b1, 1'b0, 6'd5, 16'h0);
    sb.push_back('{1'b0, 16'h8001});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("no_gnt_at_release", {gnt1, gnt0}, 2'b00);
    @(negedge clk);
    check("post_rst_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    sb.push_back('{1'b1, 16'ha5a5});
    wait_gnt(g);
    check("post_rst_gnt1", g, 2'b10);
    req1 = 1'b0;
    drain();

    // HOLD = 1 instance: back-to-back reads from requester 0.
    b_addr0 = 6'd7;
    b_req0  = 1'b1;
    last = -1; ndone = 0; nr = 0; ng = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 15) b_req0 = 1'b0;
      if (b_done0) begin
        if (last >= 0) check("h1_done_spacing", c - last, 3);
        last = c;
        ndone++;
        check("h1_rdata", b_rdata, {8'h5a, 2'b00, 6'd7});
      end
      if (b_ram_r) nr++;
      if (b_gnt0) ng++;
    end
    check("h1_enough_grants", ng >= 4, 1'b1);
    check("h1_done_per_gnt", ndone, ng);
    check("h1_ram_r_per_gnt", nr, ng);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
